// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game encodings and key box geometry (hit-test and art use the same origins)
package game_pkg;

    typedef enum logic [3:0] {
        GS_TITLE  = 4'd0,
        GS_MENU   = 4'd1,
        GS_STAGE1 = 4'd2,
        GS_STAGE2 = 4'd3,
        GS_STAGE3 = 4'd4,
        GS_BOSS   = 4'd5,
        GS_PAUSE  = 4'd6,
        GS_WIN    = 4'd7,
        GS_FAIL   = 4'd8
    } game_state_e;

    typedef enum logic [1:0] {
        KF_NONE       = 2'd0,
        KF_FIND_KEY   = 2'd1,
        KF_FIND_LIGHT = 2'd2,
        KF_FIND_DOOR  = 2'd3
    } key_find_e;

    typedef enum logic [2:0] {
        KP_IDLE,
        KP_SEARCH,
        KP_HOLD,
        KP_RELEASE,
        KP_DONE
    } kp_state_e;

    localparam logic [9:0] KEY_BOX_W = 10'd20;
    localparam logic [9:0] KEY0_X    = 10'd65;
    localparam logic [9:0] KEY0_Y    = 10'd35;
    localparam logic [9:0] KEY1_X    = 10'd235;
    localparam logic [9:0] KEY1_Y    = 10'd35;
    localparam logic [9:0] KEY2_X    = 10'd235;
    localparam logic [9:0] KEY2_Y    = 10'd205;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } box_xy_t;

    function automatic box_xy_t key_box_xy(input logic [1:0] idx);
        box_xy_t b;
        case (idx)
            2'd1:    begin b.x = KEY1_X; b.y = KEY1_Y; end
            2'd2:    begin b.x = KEY2_X; b.y = KEY2_Y; end
            default: begin b.x = KEY0_X; b.y = KEY0_Y; end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - player sprite box vs. rectangle intersection, half-open on both axes
module box_overlap #(
    parameter int PLAYER_W = 16
) (
    input  logic [8:0] player_x_i,
    input  logic [8:0] player_y_i,
    input  logic [9:0] rect_x_i,
    input  logic [9:0] rect_y_i,
    input  logic [9:0] rect_w_i,
    output logic       hit_o
);

    logic [9:0] px;
    logic [9:0] py;
    logic       hit_x;
    logic       hit_y;

    // 10-bit math: player right edge reaches 335, which must not wrap
    assign px    = {1'b0, player_x_i};
    assign py    = {1'b0, player_y_i};
    assign hit_x = (px < rect_x_i + rect_w_i) && (px + 10'(PLAYER_W) > rect_x_i);
    assign hit_y = (py < rect_y_i + rect_w_i) && (py + 10'(PLAYER_W) > rect_y_i);
    assign hit_o = hit_x && hit_y;

endmodule

// File: rtl/key_progress_ctrl.sv
// rtl/key_progress_ctrl.sv - STAGE1 key hunt sequencer: hold-to-pick keys, then door fires stage_clear
module key_progress_ctrl
    import game_pkg::*;
#(
    parameter int HOLD_FRAMES = 4,
    parameter int PLAYER_W    = 16,
    parameter int DOOR_X0     = 150,
    parameter int DOOR_Y0     = 110,
    parameter int DOOR_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic [8:0] player_x,
    input  logic [8:0] player_y,
    input  logic       pick,
    output logic [1:0] key_find,
    output logic       collecting,
    output logic       stage_clear
);

    localparam int CW = $clog2(HOLD_FRAMES + 1);

    kp_state_e  fsm_q, fsm_d;
    logic [1:0] kf_q, kf_d;
    logic [CW-1:0] hold_q, hold_d;
    logic       coll_q, coll_d;
    logic       clear_q, clear_d;

    box_xy_t    key_xy;
    logic [9:0] rect_x;
    logic [9:0] rect_y;
    logic [9:0] rect_w;
    logic       hit;

    assign key_xy = key_box_xy(kf_q);

    // Once all three keys are in, the same hit-test is pointed at the door
    always_comb begin
        rect_x = key_xy.x;
        rect_y = key_xy.y;
        rect_w = KEY_BOX_W;
        if (kf_q == KF_FIND_DOOR) begin
            rect_x = 10'(DOOR_X0);
            rect_y = 10'(DOOR_Y0);
            rect_w = 10'(DOOR_W);
        end
    end

    box_overlap #(.PLAYER_W(PLAYER_W)) u_overlap (
        .player_x_i (player_x),
        .player_y_i (player_y),
        .rect_x_i   (rect_x),
        .rect_y_i   (rect_y),
        .rect_w_i   (rect_w),
        .hit_o      (hit)
    );

    always_comb begin
        fsm_d   = fsm_q;
        kf_d    = kf_q;
        hold_d  = hold_q;
        coll_d  = coll_q;
        clear_d = 1'b0;
        if (state != GS_STAGE1) begin
            // Leaving the stage wins over any tick seen in the same cycle
            fsm_d  = KP_IDLE;
            kf_d   = KF_NONE;
            hold_d = '0;
            coll_d = 1'b0;
        end else begin
            case (fsm_q)
                KP_IDLE: fsm_d = KP_SEARCH;
                KP_SEARCH: begin
                    if (frame_tick) begin
                        if (kf_q == KF_FIND_DOOR) begin
                            if (hit) begin
                                fsm_d   = KP_DONE;
                                clear_d = 1'b1;
                            end
                        end else if (hit && pick) begin
                            fsm_d  = KP_HOLD;
                            hold_d = CW'(1);
                            coll_d = 1'b1;
                        end
                    end
                end
                KP_HOLD: begin
                    if (frame_tick) begin
                        if (hit && pick) begin
                            if (hold_q == CW'(HOLD_FRAMES - 1)) begin
                                fsm_d  = KP_RELEASE;
                                kf_d   = kf_q + 2'd1;
                                hold_d = '0;
                                coll_d = 1'b0;
                            end else begin
                                hold_d = hold_q + CW'(1);
                            end
                        end else begin
                            fsm_d  = KP_SEARCH;
                            hold_d = '0;
                            coll_d = 1'b0;
                        end
                    end
                end
                KP_RELEASE: begin
                    if (frame_tick && !pick) fsm_d = KP_SEARCH;
                end
                default: fsm_d = KP_DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= KP_IDLE;
            kf_q    <= KF_NONE;
            hold_q  <= '0;
            coll_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            kf_q    <= kf_d;
            hold_q  <= hold_d;
            coll_q  <= coll_d;
            clear_q <= clear_d;
        end
    end

    assign key_find    = kf_q;
    assign collecting  = coll_q;
    assign stage_clear = clear_q;

endmodule

// File: tb/tb_key_progress_ctrl.sv
// tb/tb_key_progress_ctrl.sv - vector table, corner sequences and randomized run against a behavioural model
module tb_key_progress_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    logic       frame_tick;
    logic [8:0] player_x;
    logic [8:0] player_y;
    logic       pick;
    logic [1:0] key_find;
    logic       collecting;
    logic       stage_clear;

    int checks = 0;
    int errors = 0;

    key_progress_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .frame_tick  (frame_tick),
        .player_x    (player_x),
        .player_y    (player_y),
        .pick        (pick),
        .key_find    (key_find),
        .collecting  (collecting),
        .stage_clear (stage_clear)
    );

    always #5 clk = ~clk;

    // Behavioural model: progress counted in keys held and frames of continuous holding
    int m_keys, m_held, m_clear;
    bit m_need_release, m_done, m_in_stage;
    int box_x[4] = '{65, 235, 235, 150};
    int box_y[4] = '{35, 35, 205, 110};

    function automatic bit overlaps(int px, int py, int bx, int by);
        return (px < bx + 20) && (px + 16 > bx) && (py < by + 20) && (py + 16 > by);
    endfunction

    task automatic model_clear();
        m_keys = 0; m_held = 0; m_clear = 0;
        m_need_release = 0; m_done = 0; m_in_stage = 0;
    endtask

    task automatic model_step(bit r, int st, bit tick, int px, int py, bit pk);
        bit ov;
        m_clear = 0;
        if (r || st != 2) begin
            model_clear();
        end else if (!m_in_stage) begin
            m_in_stage = 1;
        end else if (tick && !m_done) begin
            ov = overlaps(px, py, box_x[m_keys], box_y[m_keys]);
            if (m_need_release) begin
                if (!pk) m_need_release = 0;
            end else if (m_keys == 3) begin
                if (ov) begin m_done = 1; m_clear = 1; end
            end else if (ov && pk) begin
                m_held++;
                if (m_held == 4) begin
                    m_keys++;
                    m_held = 0;
                    m_need_release = 1;
                end
            end else begin
                m_held = 0;
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(bit r, int st, bit tick, int px, int py, bit pk);
        @(negedge clk);
        rst = r; state = 4'(st); frame_tick = tick;
        player_x = 9'(px); player_y = 9'(py); pick = pk;
        @(posedge clk);
        model_step(r, st, tick, px, py, pk);
        #1;
        chk("model key_find", int'(key_find), m_keys);
        chk("model collecting", int'(collecting), int'(m_held > 0));
        chk("model stage_clear", int'(stage_clear), m_clear);
    endtask

    typedef struct {
        bit rst; int st; bit tick; int px; int py; bit pk;
        int kf; int coll; int clr;
    } vec_t;
    vec_t vq[$];

    task automatic add(bit r, int st, bit tick, int px, int py, bit pk, int kf, int coll, int clr);
        vec_t v;
        v = '{r, st, tick, px, py, pk, kf, coll, clr};
        vq.push_back(v);
    endtask

    initial begin
        int cur_st, px, py, clears;
        bit pk;
        rst = 1; state = 0; frame_tick = 0; player_x = 0; player_y = 0; pick = 0;
        model_clear();

        // Full walkthrough: k0 at (70,40), long press into k1, abort on k2, door pulse
        add(1, 2, 0,  70,  40, 1, 0, 0, 0);
        add(0, 2, 0,  70,  40, 1, 0, 0, 0);
        add(0, 2, 1,  70,  40, 1, 0, 1, 0);
        add(0, 2, 0,  70,  40, 1, 0, 1, 0);
        add(0, 2, 1,  70,  40, 1, 0, 1, 0);
        add(0, 2, 1,  70,  40, 1, 0, 1, 0);
        add(0, 2, 1,  70,  40, 1, 1, 0, 0);
        add(0, 2, 1, 240,  40, 1, 1, 0, 0);
        add(0, 2, 1, 240,  40, 1, 1, 0, 0);
        add(0, 2, 1, 240,  40, 0, 1, 0, 0);
        add(0, 2, 1, 240,  40, 1, 1, 1, 0);
        add(0, 2, 1, 240,  40, 1, 1, 1, 0);
        add(0, 2, 1, 240,  40, 1, 1, 1, 0);
        add(0, 2, 1, 240,  40, 1, 2, 0, 0);
        add(0, 2, 1, 240, 210, 0, 2, 0, 0);
        add(0, 2, 1, 240, 210, 1, 2, 1, 0);
        add(0, 2, 1, 240, 210, 1, 2, 1, 0);
        add(0, 2, 1, 240, 210, 0, 2, 0, 0);
        add(0, 2, 1, 240, 210, 1, 2, 1, 0);
        add(0, 2, 1, 240, 210, 1, 2, 1, 0);
        add(0, 2, 1, 240, 210, 1, 2, 1, 0);
        add(0, 2, 1, 240, 210, 1, 3, 0, 0);
        add(0, 2, 1, 152, 112, 0, 3, 0, 0);
        add(0, 2, 0, 152, 112, 0, 3, 0, 0);
        add(0, 2, 1, 152, 112, 0, 3, 0, 1);
        add(0, 2, 1, 152, 112, 0, 3, 0, 0);
        add(0, 2, 1,   0,   0, 0, 3, 0, 0);
        add(0, 2, 1, 152, 112, 1, 3, 0, 0);
        foreach (vq[i]) begin
            cycle(vq[i].rst, vq[i].st, vq[i].tick, vq[i].px, vq[i].py, vq[i].pk);
            chk($sformatf("vec%0d key_find", i), int'(key_find), vq[i].kf);
            chk($sformatf("vec%0d collecting", i), int'(collecting), vq[i].coll);
            chk($sformatf("vec%0d stage_clear", i), int'(stage_clear), vq[i].clr);
        end

        // Reset held two cycles in the middle of a hold
        cycle(0, 0, 0, 70, 40, 0);
        cycle(0, 2, 0, 70, 40, 1);
        cycle(0, 2, 1, 70, 40, 1);
        cycle(0, 2, 1, 70, 40, 1);
        chk("pre-reset collecting", int'(collecting), 1);
        cycle(1, 2, 1, 70, 40, 1);
        cycle(1, 2, 1, 70, 40, 1);
        chk("reset key_find", int'(key_find), 0);
        chk("reset collecting", int'(collecting), 0);
        chk("reset stage_clear", int'(stage_clear), 0);

        // Stage exit to FAIL coinciding with a tick mid-hold, then a fresh entry
        cycle(0, 2, 0, 70, 40, 1);
        cycle(0, 2, 1, 70, 40, 1);
        cycle(0, 2, 1, 70, 40, 1);
        cycle(0, 8, 1, 70, 40, 1);
        chk("exit key_find", int'(key_find), 0);
        chk("exit collecting", int'(collecting), 0);
        cycle(0, 2, 0, 70, 40, 1);
        for (int t = 0; t < 3; t++) cycle(0, 2, 1, 70, 40, 1);
        chk("reentry three ticks key_find", int'(key_find), 0);
        chk("reentry three ticks collecting", int'(collecting), 1);
        cycle(0, 2, 1, 70, 40, 1);
        chk("reentry fourth tick key_find", int'(key_find), 1);

        // Box edges: px=49 misses k0 (49+16=65), px=50 hits; px=85 misses
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 2, 0, 49, 40, 1);
        cycle(0, 2, 1, 49, 40, 1);
        chk("edge left miss", int'(collecting), 0);
        cycle(0, 2, 1, 85, 40, 1);
        chk("edge right miss", int'(collecting), 0);
        cycle(0, 2, 1, 50, 40, 1);
        chk("edge left hit", int'(collecting), 1);

        // Randomized play steered toward the active box
        cur_st = 2; px = 70; py = 40; pk = 0; clears = 0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(99) == 0) cur_st = ($urandom_range(1) == 0) ? 8 : 0;
            else if (cur_st != 2 && $urandom_range(4) == 0) cur_st = 2;
            if ($urandom_range(9) == 0) begin
                if ($urandom_range(9) < 8) begin
                    px = box_x[m_keys] + int'($urandom_range(38)) - 17;
                    py = box_y[m_keys] + int'($urandom_range(38)) - 17;
                end else begin
                    px = int'($urandom_range(319));
                    py = int'($urandom_range(239));
                end
                if (px < 0) px = 0;
                if (py < 0) py = 0;
            end
            if ($urandom_range(7) == 0) pk = ~pk;
            cycle($urandom_range(499) == 0, cur_st, $urandom_range(2) == 0, px, py, pk);
            if (m_clear != 0) clears++;
        end
        $display("random run reached the door %0d times", clears);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
